prog_loader: RTL
================

Name: prog_loader

Overview:
Byte-stream program loader: the writer side of the program memory that the cpu fetches from through its program-memory address.
- Receives bytes from the UART receiver and frames them into 16-bit instruction words.
- Writes the words into program memory and holds the cpu in reset until a complete, checksum-valid image is stored.
- Sits between uart_rx, the program memory write port, and the cpu reset input.

Parameters:
NBITS_O, 11, program memory address width (depth 2**NBITS_O words)
NBITS_D, 16, instruction word width (fixed at 2 bytes)
SYNC, 8'hA5, frame start byte
TIMEOUT, 1000000, max idle clocks between bytes inside a frame
NBITS_T, 20, timeout counter width (must hold TIMEOUT)

Ports:
i_clk  input  1  system clock
i_reset  input  1  synchronous, active-low reset
i_RxData  input  8  received byte, valid when i_RxDone=1
i_RxDone  input  1  one-cycle byte strobe; strobes at least 2 clocks apart
o_PmWrAddr  output  NBITS_O  program memory write address
o_PmWrData  output  NBITS_D  program memory write data
o_PmWe  output  1  program memory write enable, one-cycle pulse
o_CpuHold  output  1  1 = hold cpu in reset
o_Done  output  1  image loaded and verified
o_Error  output  1  frame aborted (bad count, checksum, timeout)

Behaviour:
- All outputs registered.
- Reset (i_reset=0 at a rising edge):
  - state=IDLE.
  - o_PmWrAddr=0, o_PmWrData=0, o_PmWe=0.
  - o_CpuHold=1, o_Done=0, o_Error=0.
  - Word counter, remaining count, checksum and timeout counter cleared.
- Reset dominates all other events and aborts any frame mid-load; memory words already written are not erased.
- Frame format: SYNC, CNT_HI, CNT_LO, then CNT words each sent hi byte then lo byte, then one CHK byte.
  - CHK = XOR of all data bytes only; header bytes are excluded.
- States and transitions (each advance happens on i_RxDone):
  - IDLE: any non-SYNC byte is ignored. A SYNC byte clears the checksum and word index -> CNT_HI.
  - CNT_HI: latch the high count byte -> CNT_LO.
  - CNT_LO: form CNT = {hi, lo}.
    - CNT==0 or CNT > 2**NBITS_O -> ERROR.
    - Otherwise -> DATA_HI.
  - DATA_HI: latch the byte as the high half; checksum ^= byte -> DATA_LO.
  - DATA_LO: checksum ^= byte.
    - Next clock: o_PmWrData={hi, byte}, o_PmWrAddr=word index, o_PmWe=1 for exactly 1 cycle.
    - Word index +1; remaining -1.
    - Remaining reaches 0 -> CHECK, else -> DATA_HI.
  - CHECK: byte == checksum -> DONE, else -> ERROR.
  - DONE: o_Done=1, o_CpuHold=0. A SYNC byte re-enters CNT_HI with o_CpuHold=1 and o_Done=0. Other bytes are ignored.
  - ERROR: o_Error=1, o_CpuHold=1. A SYNC byte clears o_Error -> CNT_HI. Other bytes are ignored.
- Flag and hold timing:
  - o_CpuHold is 1 in every state except DONE.
  - o_CpuHold deasserts the clock after the CHK byte strobe, together with o_Done rising.
- Timeout:
  - Counter runs in CNT_HI..CHECK and clears on every i_RxDone.
  - Reaching TIMEOUT -> ERROR.
  - If i_RxDone arrives in the same cycle as expiry, the byte wins and is processed normally.
- Width rules:
  - Word index wraps to NBITS_O bits; the count check guarantees it never exceeds 2**NBITS_O-1.
  - Remaining count is NBITS_O+1 bits wide.
- o_PmWrAddr/o_PmWrData hold their last values when o_PmWe=0.

Test Plan:
- Basic load: after reset, stream A5 00 02 12 34 AB CD 40 -> o_PmWe pulses twice, (addr 0, 0x1234) then (addr 1, 0xABCD); o_Done=1, o_CpuHold=0 one clock after the 0x40 strobe.
- Bad checksum: same stream with last byte 0x41 -> no change to the two writes; o_Error=1, o_CpuHold=1, o_Done=0. Then a new valid frame -> o_Error=0, o_Done=1.
- Count limits:
  - A5 00 00 -> ERROR with no writes.
  - A5 08 01 (2049 > 2048) -> ERROR.
  - Count 0x0800 with 2048 words and the correct checksum -> last write at addr 0x7FF, then DONE.
- Noise and timeout: bytes 00 FF before A5 are ignored. Stall for TIMEOUT clocks after CNT_LO -> o_Error=1. A byte exactly at expiry is accepted instead.
- Reset mid-load: assert i_reset=0 after the first data word -> all outputs return to reset values, state=IDLE. A subsequent full frame loads correctly from addr 0.
- Reload from DONE: after a valid load, send A5 -> o_CpuHold=1 and o_Done=0 on the next clock; the second image overwrites from addr 0.

Source files
------------

// File: rtl/prog_loader.sv
// Byte-stream program loader: frames UART bytes into 16-bit words, writes them
// to program memory and keeps the cpu in reset until a checksum-valid image is stored.
module prog_loader #(
  parameter int unsigned NBITS_O = 11,
  parameter int unsigned NBITS_D = 16,
  parameter logic [7:0]  SYNC    = 8'hA5,
  parameter int unsigned TIMEOUT = 1000000,
  parameter int unsigned NBITS_T = 20
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [7:0]         i_RxData,
  input  logic               i_RxDone,
  output logic [NBITS_O-1:0] o_PmWrAddr,
  output logic [NBITS_D-1:0] o_PmWrData,
  output logic               o_PmWe,
  output logic               o_CpuHold,
  output logic               o_Done,
  output logic               o_Error
);

  typedef enum logic [2:0] {
    S_IDLE, S_CNT_HI, S_CNT_LO, S_DATA_HI, S_DATA_LO, S_CHECK, S_DONE, S_ERROR
  } state_e;

  localparam logic [16:0]        MAX_CNT  = 17'(2 ** NBITS_O);
  localparam logic [NBITS_T-1:0] TMO_LAST = NBITS_T'(TIMEOUT - 1);

  state_e               state_q, state_d;
  logic [7:0]           cnt_hi_q, cnt_hi_d;
  logic [7:0]           data_hi_q, data_hi_d;
  logic [7:0]           chk_q, chk_d;
  logic [NBITS_O-1:0]   idx_q, idx_d;
  logic [NBITS_O:0]     rem_q, rem_d;
  logic [NBITS_T-1:0]   tmo_q, tmo_d;
  logic [NBITS_O-1:0]   addr_q, addr_d;
  logic [NBITS_D-1:0]   wdata_q, wdata_d;
  logic                 we_q, we_d;
  logic                 hold_q, hold_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic [15:0]          cnt_w;

  assign cnt_w = {cnt_hi_q, i_RxData};

  always_comb begin
    // NOTE: every _d gets a default before the case so no path can infer a latch.
    state_d   = state_q;
    cnt_hi_d  = cnt_hi_q;
    data_hi_d = data_hi_q;
    chk_d     = chk_q;
    idx_d     = idx_q;
    rem_d     = rem_q;
    tmo_d     = tmo_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = 1'b0;

    if (i_RxDone) begin
      // A byte arriving on the expiry cycle takes priority over the timeout.
      tmo_d = '0;
      unique case (state_q)
        S_IDLE, S_DONE, S_ERROR: begin
          if (i_RxData == SYNC) begin
            chk_d   = '0;
            idx_d   = '0;
            state_d = S_CNT_HI;
          end
        end
        S_CNT_HI: begin
          cnt_hi_d = i_RxData;
          state_d  = S_CNT_LO;
        end
        S_CNT_LO: begin
          if (cnt_w == 16'd0 || {1'b0, cnt_w} > MAX_CNT) begin
            state_d = S_ERROR;
          end else begin
            rem_d   = (NBITS_O + 1)'(cnt_w);
            state_d = S_DATA_HI;
          end
        end
        S_DATA_HI: begin
          data_hi_d = i_RxData;
          chk_d     = chk_q ^ i_RxData;
          state_d   = S_DATA_LO;
        end
        S_DATA_LO: begin
          chk_d   = chk_q ^ i_RxData;
          addr_d  = idx_q;
          wdata_d = NBITS_D'({data_hi_q, i_RxData});
          we_d    = 1'b1;
          idx_d   = idx_q + NBITS_O'(1);
          rem_d   = rem_q - (NBITS_O + 1)'(1);
          state_d = (rem_q == (NBITS_O + 1)'(1)) ? S_CHECK : S_DATA_HI;
        end
        S_CHECK: state_d = (i_RxData == chk_q) ? S_DONE : S_ERROR;
        default: ;
      endcase
    end else if (state_q inside {S_CNT_HI, S_CNT_LO, S_DATA_HI, S_DATA_LO, S_CHECK}) begin
      if (tmo_q == TMO_LAST) begin
        tmo_d   = '0;
        state_d = S_ERROR;
      end else begin
        tmo_d = tmo_q + NBITS_T'(1);
      end
    end

    // Flags are registered from the next state so they move on the clock after the strobe.
    hold_d = (state_d != S_DONE);
    done_d = (state_d == S_DONE);
    err_d  = (state_d == S_ERROR);
  end

  // NOTE: sequential state uses non-blocking assignments only; reset here is synchronous.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q   <= S_IDLE;
      cnt_hi_q  <= '0;
      data_hi_q <= '0;
      chk_q     <= '0;
      idx_q     <= '0;
      rem_q     <= '0;
      tmo_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      hold_q    <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_hi_q  <= cnt_hi_d;
      data_hi_q <= data_hi_d;
      chk_q     <= chk_d;
      idx_q     <= idx_d;
      rem_q     <= rem_d;
      tmo_q     <= tmo_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      hold_q    <= hold_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign o_PmWrAddr = addr_q;
  assign o_PmWrData = wdata_q;
  assign o_PmWe     = we_q;
  assign o_CpuHold  = hold_q;
  assign o_Done     = done_q;
  assign o_Error    = err_q;

endmodule
